// File: rtl/cs_pkg.sv
// Shared constants and types for the CS stream sequencer and its result FIFO.
package cs_pkg;
    localparam int XW        = 8;
    localparam int YW        = 10;
    localparam int WIN       = 9;
    localparam int OUT_DEPTH = 4;
    localparam int FCW       = 4;
    localparam int RCW       = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_e;

    typedef logic [YW-1:0] result_t;
endpackage

// File: rtl/cs_res_fifo.sv
// Synchronous result FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module cs_res_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    output logic [OW-1:0] occ_o,
    output logic [W-1:0]  head_o,
    output logic          valid_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [OW-1:0] occ_q;
    logic          do_push_s;
    logic          do_pop_s;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop_s  = pop_i && (occ_q != '0);
    assign do_push_s = push_i && ((occ_q != OW'(DEPTH)) || do_pop_s);
    assign occ_o     = occ_q;
    assign valid_o   = (occ_q != '0);
    assign head_o    = mem_q[rd_q];

    // Storage array carries no reset; only the pointers define valid content.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            occ_q <= '0;
        end else begin
            if (do_push_s) wr_q <= next_ptr(wr_q);
            if (do_pop_s)  rd_q <= next_ptr(rd_q);
            case ({do_push_s, do_pop_s})
                2'b10:   occ_q <= occ_q + OW'(1);
                2'b01:   occ_q <= occ_q - OW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end
endmodule

// File: rtl/cs_stream_ctrl.sv
// Sequencer for the 9-tap CS datapath: sample intake, window fill tracking,
// result capture one cycle after each full-window shift, and output buffering.
module cs_stream_ctrl
    import cs_pkg::*;
#(
    parameter int P_XW        = XW,
    parameter int P_YW        = YW,
    parameter int P_WIN       = WIN,
    parameter int P_OUT_DEPTH = OUT_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [P_XW-1:0]   in_data,
    output logic              in_ready,
    input  logic              flush,
    output logic              dp_shift,
    output logic [P_XW-1:0]   dp_x,
    output logic              dp_clear,
    input  logic [P_YW-1:0]   dp_y,
    output logic              out_valid,
    output logic [P_YW-1:0]   out_data,
    input  logic              out_ready,
    output logic [FCW-1:0]    fill_cnt,
    output logic [RCW-1:0]    res_cnt
);
    localparam int OW = $clog2(P_OUT_DEPTH + 1);

    state_e         state_q, state_d;
    logic [FCW-1:0] fill_q, fill_d;
    logic [RCW-1:0] res_q, res_d;
    logic           cap_pend_q, cap_pend_d;

    logic [OW-1:0]  fifo_occ_s;
    logic [OW:0]    committed_s;
    logic [FCW-1:0] fill_inc_s;
    logic           accept_s;
    logic           clearing_s;

    // A pending capture already owns a FIFO slot, so it counts against space.
    assign committed_s = {1'b0, fifo_occ_s} + (OW+1)'(cap_pend_q);
    assign in_ready    = !reset && !flush && (state_q != FLUSH)
                         && (committed_s < (OW+1)'(P_OUT_DEPTH));
    assign accept_s    = in_valid && in_ready;
    assign fill_inc_s  = (fill_q >= FCW'(P_WIN)) ? fill_q : fill_q + FCW'(1);
    assign clearing_s  = flush || (state_q == FLUSH);

    assign dp_shift = accept_s;
    assign dp_x     = in_data;
    assign dp_clear = (state_q == FLUSH);
    assign fill_cnt = fill_q;
    assign res_cnt  = res_q;

    // Next-state, counter and capture-pending logic.
    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        res_d      = res_q;
        cap_pend_d = accept_s && (fill_inc_s == FCW'(P_WIN));

        if (flush) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        state_d = (fill_inc_s == FCW'(P_WIN)) ? RUN : FILL;
                    end else begin
                        state_d = IDLE;
                    end
                end
                FILL: begin
                    if (accept_s && (fill_inc_s == FCW'(P_WIN))) begin
                        state_d = RUN;
                    end else begin
                        state_d = FILL;
                    end
                end
                RUN:     state_d = RUN;
                FLUSH:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        if (clearing_s) begin
            fill_d = '0;
            res_d  = '0;
        end else begin
            if (accept_s) begin
                fill_d = fill_inc_s;
            end else begin
                fill_d = fill_q;
            end
            if (cap_pend_q) begin
                res_d = res_q + RCW'(1);
            end else begin
                res_d = res_q;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fill_q     <= '0;
            res_q      <= '0;
            cap_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            res_q      <= res_d;
            cap_pend_q <= cap_pend_d;
        end
    end

    cs_res_fifo #(
        .W     (P_YW),
        .DEPTH (P_OUT_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (cap_pend_q),
        .push_data_i (dp_y),
        .pop_i       (out_ready),
        .occ_o       (fifo_occ_s),
        .head_o      (out_data),
        .valid_o     (out_valid)
    );
endmodule

// File: tb/tb_cs_stream_ctrl.sv
// Scoreboard bench for cs_stream_ctrl with a behavioural 9-tap datapath stand-in.
module tb_cs_stream_ctrl;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        flush;
    logic        dp_shift;
    logic [7:0]  dp_x;
    logic        dp_clear;
    logic [9:0]  dp_y;
    logic        out_valid;
    logic [9:0]  out_data;
    logic        out_ready;
    logic [3:0]  fill_cnt;
    logic [15:0] res_cnt;

    cs_stream_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .dp_shift  (dp_shift),
        .dp_x      (dp_x),
        .dp_clear  (dp_clear),
        .dp_y      (dp_y),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .fill_cnt  (fill_cnt),
        .res_cnt   (res_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: 9-sample window, result = (sum + sum) / 8.
    logic [7:0] dpw [9];
    always @(posedge clk) begin
        if (reset || dp_clear) begin
            for (int i = 0; i < 9; i++) dpw[i] <= 8'd0;
        end else if (dp_shift) begin
            dpw[0] <= dp_x;
            for (int i = 1; i < 9; i++) dpw[i] <= dpw[i-1];
        end
    end
    always_comb begin
        int s;
        s = 0;
        for (int i = 0; i < 9; i++) s = s + int'(dpw[i]);
        dp_y = 10'((s + s) / 8);
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted samples since last flush/reset, results in flight.
    int m_win[$];
    int exp_q[$];
    bit m_known = 0;
    int m_acc, m_res, m_occ, m_pend, m_fl;

    always @(negedge clk) begin
        int exp_ir;
        int acc;
        int pop;
        int s;
        exp_ir = (!reset && !flush && m_known && m_fl == 0 && (m_occ + m_pend) < 4) ? 1 : 0;
        if (reset) check("in_ready_in_reset", int'(in_ready), 0);
        if (m_known) begin
            check("in_ready",  int'(in_ready),  exp_ir);
            check("out_valid", int'(out_valid), (m_occ > 0) ? 1 : 0);
            check("fill_cnt",  int'(fill_cnt),  (m_acc > 9) ? 9 : m_acc);
            check("res_cnt",   int'(res_cnt),   m_res % 65536);
            check("dp_clear",  int'(dp_clear),  m_fl);
            check("dp_shift",  int'(dp_shift),  (in_valid && exp_ir == 1) ? 1 : 0);
            check("dp_x",      int'(dp_x),      int'(in_data));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 1, 0);
                end else begin
                    check("out_data", int'(out_data), exp_q.pop_front());
                end
            end
        end
        if (reset) begin
            m_win.delete();
            exp_q.delete();
            m_known = 1;
            m_acc = 0; m_res = 0; m_occ = 0; m_pend = 0; m_fl = 0;
        end else if (m_known) begin
            acc = (in_valid && exp_ir == 1) ? 1 : 0;
            pop = (m_occ > 0 && out_ready) ? 1 : 0;
            m_occ = m_occ + m_pend - pop;
            if (flush || m_fl == 1) begin
                m_acc = 0;
                m_res = 0;
                m_win.delete();
                m_pend = 0;
            end else begin
                if (m_pend == 1) m_res++;
                m_pend = 0;
                if (acc == 1) begin
                    m_win.push_back(int'(in_data));
                    if (m_win.size() > 9) void'(m_win.pop_front());
                    m_acc++;
                    if (m_acc >= 9) begin
                        s = 0;
                        foreach (m_win[i]) s += m_win[i];
                        exp_q.push_back((s + s) / 8);
                        m_pend = 1;
                    end
                end
            end
            m_fl = flush ? 1 : 0;
        end
    end

    task automatic drive(input bit iv, input int d, input bit fl, input bit ordy);
        in_valid  = iv;
        in_data   = 8'(d);
        flush     = fl;
        out_ready = ordy;
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        reset = 1'b0;
        drive(0, 0, 0, 1);

        // Nine samples of 10: one result of 22.
        for (int i = 0; i < 9; i++) drive(1, 10, 0, 1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        check("res_after_first_window", int'(res_cnt), 1);

        // Flush, then 1..9 back-to-back: single result 11.
        drive(0, 0, 1, 1);
        drive(0, 0, 0, 1);
        for (int i = 1; i <= 9; i++) drive(1, i, 0, 1);
        drive(0, 0, 0, 1);

        // Backpressure: window full, 20 more offered with consumer stalled.
        for (int i = 0; i < 20; i++) drive(1, 20 + i * 7, 0, 0);
        check("in_ready_stalled", int'(in_ready), 0);
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 1);

        // Flush after 5 samples, then 9 more.
        drive(0, 0, 1, 1);
        drive(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(1, 100 + i, 0, 1);
        drive(0, 0, 1, 1);
        drive(0, 0, 0, 1);
        for (int i = 0; i < 9; i++) drive(1, 200 + i * 5, 0, 1);
        drive(0, 0, 0, 1);

        // Flush in the same cycle as a pending capture; that cycle's sample is rejected.
        drive(1, 77, 0, 1);
        drive(1, 88, 1, 1);
        drive(1, 99, 1, 1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);

        // Randomized traffic including rare flushes.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                  $urandom_range(0, 40) == 0, $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 1);
        check("scoreboard_drained", exp_q.size(), 0);

        // Reset mid-run with results still buffered.
        for (int i = 0; i < 12; i++) drive(1, 30 + i, 0, 0);
        reset = 1'b1;
        drive(1, 5, 0, 0);
        reset = 1'b0;
        check("out_valid_after_reset", int'(out_valid), 0);
        check("fill_after_reset", int'(fill_cnt), 0);
        for (int i = 0; i < 11; i++) drive(1, 3 * i, 0, 1);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 1);
        check("final_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
